// File: rtl/out_fifo_pkg.sv
// -----------------------------------------------------------------------------
// out_fifo_pkg
// Shared sizing helpers for the core output-port FIFO:
//   addr_width  - port address width, $clog2(n_ports) but never below 1
//   occ_width   - occupancy counter width, able to hold the value `depth`
//   entry_width - width of one packed {addr, data} storage entry
// -----------------------------------------------------------------------------
package out_fifo_pkg;

  localparam int NUBITS_DEFAULT = 32;
  localparam int NUIOOU_DEFAULT = 8;
  localparam int FDEPTH_DEFAULT = 16;
  localparam int AFULL_DEFAULT  = 12;

  function automatic int addr_width(input int n_ports);
    if (n_ports <= 1) begin
      return 1;
    end else begin
      return $clog2(n_ports);
    end
  endfunction

  function automatic int occ_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int entry_width(input int aw, input int dw);
    return aw + dw;
  endfunction

endpackage

// File: rtl/out_fifo_regfile.sv
// -----------------------------------------------------------------------------
// fifo_regfile
// Dual-port register array: synchronous write port, asynchronous read port.
// Contents are deliberately not reset; the control logic never presents an
// unwritten entry as valid.
// Ports:
//   clk     - write clock
//   we_i    - write enable
//   waddr_i - write index
//   wdata_i - write data
//   raddr_i - read index
//   rdata_o - read data (combinational from the array)
// -----------------------------------------------------------------------------
module fifo_regfile #(
  parameter int WIDTH = 35,
  parameter int DEPTH = 16,
  localparam int IW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [IW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [IW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/out_fifo.sv
// -----------------------------------------------------------------------------
// out_fifo
// Buffers every core output write {port address, data} in a circular FIFO and
// drains it to external sinks through a show-ahead valid/ready handshake. The
// core cannot be stalled, so a write arriving while the FIFO is full (and
// nothing is leaving) is dropped and recorded in a sticky overflow flag.
// FDEPTH must be a power of two and >= 2 so the pointers wrap naturally.
// Ports:
//   clk, rst             - clock, asynchronous active-high reset
//   out_en/addr_out/data_out - core write strobe, port address, data word
//   o_valid/o_ready      - head entry present / consumer accepts head
//   o_addr/o_data        - head entry contents (don't-care when !o_valid)
//   count/full/almost_full - occupancy and derived level flags
//   overflow/ovf_clr     - sticky dropped-write flag and its clear
// -----------------------------------------------------------------------------
module out_fifo
  import out_fifo_pkg::*;
#(
  parameter int  NUBITS = NUBITS_DEFAULT,
  parameter int  NUIOOU = NUIOOU_DEFAULT,
  parameter int  FDEPTH = FDEPTH_DEFAULT,
  parameter int  AFULL  = AFULL_DEFAULT,
  localparam int AW     = addr_width(NUIOOU),
  localparam int CW     = occ_width(FDEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              out_en,
  input  logic [AW-1:0]     addr_out,
  input  logic [NUBITS-1:0] data_out,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [AW-1:0]     o_addr,
  output logic [NUBITS-1:0] o_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              almost_full,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int PW = $clog2(FDEPTH);
  localparam int EW = entry_width(AW, NUBITS);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overflow_q, overflow_d;

  logic          push_s;
  logic          pop_s;
  logic          drop_s;
  logic [EW-1:0] wr_entry_s;
  logic [EW-1:0] rd_entry_s;

  // Level flags come from the count register only, never from out_en/o_ready.
  assign o_valid     = (count_q != {CW{1'b0}});
  assign full        = (count_q == CW'(FDEPTH));
  assign almost_full = (count_q >= CW'(AFULL));
  assign count       = count_q;
  assign overflow    = overflow_q;

  assign pop_s  = o_valid & o_ready;
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push_s = out_en & (~full | pop_s);
  assign drop_s = out_en & full & ~pop_s;

  assign wr_entry_s = {addr_out, data_out};
  assign o_addr     = rd_entry_s[EW-1:NUBITS];
  assign o_data     = rd_entry_s[NUBITS-1:0];

  fifo_regfile #(
    .WIDTH (EW),
    .DEPTH (FDEPTH)
  ) u_regfile (
    .clk     (clk),
    .we_i    (push_s),
    .waddr_i (wr_ptr_q),
    .wdata_i (wr_entry_s),
    .raddr_i (rd_ptr_q),
    .rdata_o (rd_entry_s)
  );

  // Next-state for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Set beats clear when both happen in the same cycle.
    if (drop_s) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end else begin
      overflow_d = overflow_q;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= {PW{1'b0}};
      rd_ptr_q   <= {PW{1'b0}};
      count_q    <= {CW{1'b0}};
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_out_fifo.sv
module tb_out_fifo;

  localparam int NUBITS = 32;
  localparam int AW     = 3;
  localparam int CW     = 5;
  localparam int EW     = AW + NUBITS;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              out_en = 1'b0;
  logic [AW-1:0]     addr_out = '0;
  logic [NUBITS-1:0] data_out = '0;
  logic              o_valid;
  logic              o_ready = 1'b0;
  logic [AW-1:0]     o_addr;
  logic [NUBITS-1:0] o_data;
  logic [CW-1:0]     count;
  logic              full;
  logic              almost_full;
  logic              overflow;
  logic              ovf_clr = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [EW-1:0] sb[$];
  logic [EW-1:0] exp_e;

  out_fifo #(
    .NUBITS (32),
    .NUIOOU (8),
    .FDEPTH (16),
    .AFULL  (12)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .out_en      (out_en),
    .addr_out    (addr_out),
    .data_out    (data_out),
    .o_valid     (o_valid),
    .o_ready     (o_ready),
    .o_addr      (o_addr),
    .o_data      (o_data),
    .count       (count),
    .full        (full),
    .almost_full (almost_full),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    checks++;
    if (o_valid !== 1'b0 || count !== 5'd0 || full !== 1'b0 || overflow !== 1'b0 || almost_full !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: valid=%b count=%0d full=%b afull=%b ovf=%b, want 0/0/0/0/0",
               o_valid, count, full, almost_full, overflow);
    end
    cyc();
    rst = 1'b0;
    cyc();
    cyc();
    checks++;
    if (o_valid !== 1'b0 || count !== 5'd0) begin
      failures++;
      $display("FAIL idle_after_reset: valid=%b count=%0d, want 0/0", o_valid, count);
    end
  endtask

  task automatic test_single();
    out_en = 1'b1; addr_out = 3'd3; data_out = 32'h0000_00A5;
    o_ready = 1'b0;
    sb.push_back({3'd3, 32'h0000_00A5});
    cyc();
    out_en = 1'b0;
    exp_e = sb.pop_front();
    checks++;
    if (o_valid !== 1'b1 || {o_addr, o_data} !== exp_e || count !== 5'd1) begin
      failures++;
      $display("FAIL single_word: valid=%b addr=%0d data=%h count=%0d, want 1/%0d/%h/1",
               o_valid, o_addr, o_data, count, exp_e[EW-1:NUBITS], exp_e[NUBITS-1:0]);
    end
    o_ready = 1'b1;
    cyc();
    o_ready = 1'b0;
    checks++;
    if (count !== 5'd0 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL single_pop: count=%0d valid=%b, want 0/0", count, o_valid);
    end
  endtask

  // Fill with values base..base+15; checks level flags on the way up.
  task automatic fill16(input int base, input string tag);
    for (int i = 1; i <= 16; i++) begin
      out_en = 1'b1;
      addr_out = 3'(i);
      data_out = 32'(base + i - 1);
      sb.push_back({3'(i), 32'(base + i - 1)});
      cyc();
      checks++;
      if (count !== 5'(i) || almost_full !== (i >= 12) || full !== (i == 16)) begin
        failures++;
        $display("FAIL %s_level[%0d]: count=%0d afull=%b full=%b, want %0d/%b/%b",
                 tag, i, count, almost_full, full, i, (i >= 12), (i == 16));
      end
    end
    out_en = 1'b0;
  endtask

  // Drain everything the scoreboard holds, comparing each head.
  task automatic drain(input string tag);
    int n;
    n = sb.size();
    o_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      exp_e = sb.pop_front();
      checks++;
      if (o_valid !== 1'b1 || {o_addr, o_data} !== exp_e) begin
        failures++;
        $display("FAIL %s_drain[%0d]: valid=%b addr=%0d data=%0d, want 1/%0d/%0d",
                 tag, i, o_valid, o_addr, o_data, exp_e[EW-1:NUBITS], exp_e[NUBITS-1:0]);
      end
      cyc();
    end
    o_ready = 1'b0;
    checks++;
    if (count !== 5'd0 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_empty: count=%0d valid=%b, want 0/0", tag, count, o_valid);
    end
  endtask

  task automatic test_fill_overflow();
    fill16(1, "fill");
    out_en = 1'b1; addr_out = 3'd7; data_out = 32'd99;
    cyc();
    out_en = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
      failures++;
      $display("FAIL drop_on_full: ovf=%b count=%0d full=%b, want 1/16/1", overflow, count, full);
    end
    drain("fill");
  endtask

  task automatic test_ovf_clr();
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear: ovf=%b, want 0", overflow);
    end
    fill16(100, "ovf");
    out_en = 1'b1; data_out = 32'd55; ovf_clr = 1'b1;
    cyc();
    out_en = 1'b0; ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b1 || count !== 5'd16) begin
      failures++;
      $display("FAIL ovf_set_wins: ovf=%b count=%0d, want 1/16", overflow, count);
    end
    drain("ovf");
    ovf_clr = 1'b1;
    cyc();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clear2: ovf=%b, want 0", overflow);
    end
  endtask

  task automatic test_full_push_pop();
    fill16(1, "fpp");
    out_en = 1'b1; addr_out = 3'd5; data_out = 32'd77; o_ready = 1'b1;
    exp_e = sb.pop_front();
    checks++;
    if (o_valid !== 1'b1 || {o_addr, o_data} !== exp_e) begin
      failures++;
      $display("FAIL fpp_head: valid=%b data=%0d, want 1/%0d", o_valid, o_data, exp_e[NUBITS-1:0]);
    end
    sb.push_back({3'd5, 32'd77});
    cyc();
    out_en = 1'b0; o_ready = 1'b0;
    checks++;
    if (count !== 5'd16 || overflow !== 1'b0 || full !== 1'b1) begin
      failures++;
      $display("FAIL fpp_level: count=%0d ovf=%b full=%b, want 16/0/1", count, overflow, full);
    end
    drain("fpp");
  endtask

  task automatic test_streaming();
    o_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i > 0) begin
        exp_e = sb.pop_front();
        checks++;
        if (o_valid !== 1'b1 || {o_addr, o_data} !== exp_e) begin
          failures++;
          $display("FAIL stream_data[%0d]: valid=%b data=%0d, want 1/%0d",
                   i, o_valid, o_data, exp_e[NUBITS-1:0]);
        end
      end
      out_en = 1'b1; addr_out = 3'(i); data_out = 32'(i);
      sb.push_back({3'(i), 32'(i)});
      cyc();
      checks++;
      if (count !== 5'd1) begin
        failures++;
        $display("FAIL stream_count[%0d]: count=%0d, want 1", i, count);
      end
    end
    out_en = 1'b0;
    drain("stream");
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      out_en = 1'b1; addr_out = 3'(i); data_out = 32'(200 + i);
      cyc();
    end
    out_en = 1'b0;
    checks++;
    if (count !== 5'd5) begin
      failures++;
      $display("FAIL mid_pre: count=%0d, want 5", count);
    end
    rst = 1'b1;
    #2;
    checks++;
    if (count !== 5'd0 || o_valid !== 1'b0 || full !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: count=%0d valid=%b full=%b, want 0/0/0", count, o_valid, full);
    end
    sb.delete();
    cyc();
    rst = 1'b0;
    cyc();
    checks++;
    if (count !== 5'd0 || o_valid !== 1'b0) begin
      failures++;
      $display("FAIL mid_after: count=%0d valid=%b, want 0/0", count, o_valid);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_fill_overflow();
    test_ovf_clr();
    test_full_push_pop();
    test_streaming();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/out_fifo.md
# out_fifo

Output-port buffer between the processor core's output interface and the external sinks. Captures every core output write (port address plus data word, strobed by `out_en`) into a circular FIFO and drains it through a valid/ready handshake. Slow or bursty consumers therefore never lose a word while the FIFO has space. The core cannot stall, so an overflow is recorded in a sticky flag and never back-pressures the core.

## Interface
Parameters:
- `NUBITS`, 32, data word width; matches the core data path.
- `NUIOOU`, 8, number of output port addresses; the address width is `$clog2(NUIOOU)`, forced to 1 when `NUIOOU` ≤ 1.
- `FDEPTH`, 16, FIFO entries; must be a power of two and ≥ 2.
- `AFULL`, 12, `almost_full` asserts when the occupancy is ≥ `AFULL`.

Ports:
- `clk`  in  1  single clock; everything is sampled on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `out_en`  in  1  write strobe from the core.
- `addr_out`  in  AW  port address from the core.
- `data_out`  in  `NUBITS`  data word from the core.
- `o_valid`  out  1  head entry is present.
- `o_ready`  in  1  consumer accepts the head entry.
- `o_addr`  out  AW  port address of the head entry.
- `o_data`  out  `NUBITS`  data word of the head entry.
- `count`  out  `$clog2(FDEPTH)+1`  current occupancy.
- `full`  out  1  `count == FDEPTH`.
- `almost_full`  out  1  `count >= AFULL`.
- `overflow`  out  1  sticky: a write was dropped.
- `ovf_clr`  in  1  clears `overflow`.

## Operation
- Storage: `FDEPTH` entries of {addr, data}. `wr_ptr` and `rd_ptr` are `$clog2(FDEPTH)` bits wide, wrap naturally, and `count` is held in a separate register.
- `push` = `out_en` & (!`full` | `pop`).
- `pop` = `o_valid` & `o_ready`.
- Push: write {`addr_out`, `data_out`} at `wr_ptr`, then `wr_ptr`+1.
- Pop: `rd_ptr`+1.
- `count`: +1 on push only, −1 on pop only, unchanged when both occur or neither occurs.
- Show-ahead output: `o_addr`/`o_data` = the entry at `rd_ptr`; `o_valid` = (`count` != 0). `o_addr`/`o_data` are don't-care while `o_valid` = 0.
- Full with simultaneous `out_en` and `pop`: the write is accepted and `count` stays at `FDEPTH`.
- Full with `out_en` and no pop: the write is dropped, `overflow` is set, and pointers and `count` are unchanged.
- Empty with `out_en`: the entry is written and there is no combinational bypass; `o_valid` rises after the edge.
- Empty with `o_ready`: no effect; the pointers never underflow.
- `overflow` priority: if a set event and `ovf_clr` occur in the same cycle, set wins.
- `o_ready` may be asserted while `o_valid` = 0; it is ignored.
- Once `o_valid` is high, it stays high until a pop occurs. The head entry stays stable until popped.

## Timing
- Reset (asynchronous, applied immediately):
  - `wr_ptr` = `rd_ptr` = 0, `count` = 0, `overflow` = 0.
  - Outputs: `o_valid` = 0, `full` = 0, `almost_full` = 0.
  - Storage contents are not reset.
- Reset asserted mid-operation empties the FIFO immediately; all in-flight entries are discarded.
- Write-to-read latency is 1 cycle: an `out_en` sampled at edge N gives `o_valid` = 1 with that data after edge N.
- Throughput is one push and one pop per cycle, sustained.
- `full`, `almost_full` and `count` are registered-derived; they update after the edge and have no combinational path from `out_en` or `o_ready`.
- `o_valid`/`o_addr`/`o_data` depend only on registers. No combinational path exists from `o_ready` to any output.

## Structure
- Shared package: the address-width function (`$clog2` with the `NUIOOU` ≤ 1 → 1 rule), the occupancy-width constant, and the {addr, data} entry packing/unpacking widths.
- One natural sub-module: `fifo_regfile`, a parameterised dual-port register array with synchronous write and asynchronous read, width `AW+NUBITS` and depth `FDEPTH`. The pointer/count/flag control stays in `out_fifo`.
- Target size is about 150–250 RTL lines in total.

## Test plan
- Reset then idle: `o_valid` = 0, `count` = 0, `full` = 0, `overflow` = 0. Assert `rst` mid-burst at `count` = 5; outputs immediately show `count` = 0, `o_valid` = 0.
- Single word: `out_en` with addr = 3, data = `32'h0000_00A5` and `o_ready` = 0. After one edge, `o_valid` = 1, `o_addr` = 3, `o_data` = `A5`, `count` = 1. Raise `o_ready`; after one edge, `count` = 0.
- Fill to 16 with data 1..16 and `o_ready` = 0: `almost_full` rises at `count` = 12 and `full` at 16. A 17th write (data 99) is dropped and sets `overflow`. Draining returns 1..16 in order, never 99.
- Full with simultaneous push and pop: data 77 is accepted, `count` stays 16, and `overflow` stays 0. Draining yields 2..16 then 77.
- Streaming: `out_en` every cycle with data 0..99 and `o_ready` = 1 every cycle. `count` stays at 1 after the first edge; the consumer sees 0..99 in order with no gaps.
- `ovf_clr`: with `overflow` = 1, pulse `ovf_clr` → `overflow` = 0 next cycle. Pulse `ovf_clr` in the same cycle as a dropped write → `overflow` stays 1.
